// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state and next-PC source types for the fetch PC generator.
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  typedef enum logic [2:0] {SRC_HOLD, SRC_SEQ, SRC_RAS, SRC_REDIR, SRC_TRAP} src_t;
endpackage

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: circular return-address stack; pushing when full overwrites the oldest entry.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr, ptr_inc;
  logic [AW:0] count;
  assign ptr_inc = ptr + 1'b1;
  assign top = mem[ptr];
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= data;
    end else if (push) begin
      mem[ptr_inc] <= data;
      ptr <= ptr_inc;
      count <= (count == (AW+1)'(DEPTH)) ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/redirect/sequential selection, stall and halt.
// Optional return-address stack compiled in with `define RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             halt_req,
  input  logic             call_push,
  input  logic             ret_pop,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             halted
);
  state_t state, state_n;
  src_t src;
  logic accept, live, ras_hit;
  logic [WIDTH-1:0] ras_top, next_pc;
  assign pc_plus_step = fetch_pc + WIDTH'(STEP);
  assign accept = fetch_valid & fetch_ready & ~stall;
  assign live = state != BOOT;
`ifdef RAS_EN
  logic ras_empty, seq_acc;
  // Stack only moves on a fetch that actually retires sequentially.
  assign seq_acc = accept & ~trap_valid & ~redirect_valid;
  assign ras_hit = ret_pop & ~ras_empty;
  pc_gen_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(CLK),
    .rst(RST),
    .push(seq_acc & call_push),
    .pop(seq_acc & ret_pop),
    .data(pc_plus_step),
    .top(ras_top),
    .empty(ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = call_push ^ ret_pop ^ (RAS_DEPTH == 0);
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif
  always_comb begin
    src = (live && trap_valid) ? SRC_TRAP :
          (live && redirect_valid) ? SRC_REDIR :
          accept ? (ras_hit ? SRC_RAS : SRC_SEQ) : SRC_HOLD;
    next_pc = (src == SRC_TRAP) ? trap_vector :
              (src == SRC_REDIR) ? redirect_target :
              (src == SRC_RAS) ? ras_top :
              (src == SRC_SEQ) ? pc_plus_step : fetch_pc;
    // halt_req wins over a simultaneous wake-up so halt+redirect still parks.
    state_n = (state == BOOT) ? RUN :
              halt_req ? HALT :
              (state == HALT && !(trap_valid || redirect_valid)) ? HALT : RUN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BOOT;
      fetch_pc <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= next_pc;
      fetch_valid <= state_n == RUN;
      halted <= state_n == HALT;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table, RAS call/return sequence and randomized run vs a queue-based model.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h100;
  logic CLK = 1'b0;
  logic RST, stall, fetch_ready, redirect_valid, trap_valid, halt_req, call_push, ret_pop;
  logic [31:0] redirect_target, trap_vector, fetch_pc, pc_plus_step;
  logic fetch_valid, halted;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  pc_gen #(.WIDTH(32), .RESET_VECTOR(RV), .STEP(4), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
    .call_push(call_push), .ret_pop(ret_pop), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .pc_plus_step(pc_plus_step), .halted(halted)
  );
  typedef struct {
    logic rst, stall, ready, redir;
    logic [31:0] rt;
    logic trap;
    logic [31:0] tv;
    logic halt;
    logic v;
    logic [31:0] pc;
    logic h;
  } vec_t;
  vec_t vecs[$];
  logic m_boot, m_halted, m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic idle();
    RST = 0; stall = 0; fetch_ready = 1; redirect_valid = 0; trap_valid = 0;
    halt_req = 0; call_push = 0; ret_pop = 0; redirect_target = '0; trap_vector = '0;
  endtask
  // Reference: priority rules and a bounded queue for the return stack.
  task automatic model_step();
    logic acc;
    logic [31:0] seq, nxt;
    acc = m_valid & fetch_ready & !stall;
    if (RST) begin
      m_pc = RV; m_boot = 1; m_halted = 0; m_q.delete();
    end else begin
      if (!m_boot && trap_valid) m_pc = trap_vector;
      else if (!m_boot && redirect_valid) m_pc = redirect_target;
      else if (acc) begin
        seq = m_pc + 32'd4;
        nxt = seq;
`ifdef RAS_EN
        if (ret_pop && m_q.size() > 0) begin
          nxt = m_q[$];
          void'(m_q.pop_back());
          if (call_push) m_q.push_back(seq);
        end else if (call_push) begin
          m_q.push_back(seq);
          if (m_q.size() > 4) void'(m_q.pop_front());
        end
`endif
        m_pc = nxt;
      end
      if (m_boot) m_halted = 0;
      else if (halt_req) m_halted = 1;
      else if (trap_valid || redirect_valid) m_halted = 0;
      m_boot = 0;
    end
    m_valid = !m_boot && !m_halted;
  endtask
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask
  function automatic vec_t mk(logic rst, logic st, logic rdy, logic rd, logic [31:0] rt,
                              logic tr, logic [31:0] tv, logic hl, logic v, logic [31:0] pc, logic h);
    vec_t x;
    x.rst = rst; x.stall = st; x.ready = rdy; x.redir = rd; x.rt = rt; x.trap = tr;
    x.tv = tv; x.halt = hl; x.v = v; x.pc = pc; x.h = h;
    return x;
  endfunction
  initial begin
    logic [31:0] exp_ret[5];
    idle();
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 0,32'h100,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h100,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h104,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h108,0));
    vecs.push_back(mk(0,0,1,1,32'h200,0,0,0, 1,32'h200,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h200,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h200,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h200,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h204,0));
    vecs.push_back(mk(0,1,1,1,32'h400,1,32'h80,0, 1,32'h80,0));
    vecs.push_back(mk(0,0,1,1,32'h300,0,0,0, 1,32'h300,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,32'h300,1));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 0,32'h300,1));
    vecs.push_back(mk(0,0,1,1,32'h500,0,0,0, 1,32'h500,0));
    vecs.push_back(mk(0,0,1,1,32'hFFFF_FFFC,0,0,0, 1,32'hFFFF_FFFC,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,32'h4,0));
    vecs.push_back(mk(0,0,1,1,32'h600,0,0,1, 0,32'h600,1));
    vecs.push_back(mk(0,0,1,0,0,1,32'h700,0, 1,32'h700,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0, 1,32'h700,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h100,0));
    vecs.push_back(mk(0,0,1,1,32'h900,0,0,0, 1,32'h100,0));
    foreach (vecs[i]) begin
      idle();
      RST = vecs[i].rst; stall = vecs[i].stall; fetch_ready = vecs[i].ready;
      redirect_valid = vecs[i].redir; redirect_target = vecs[i].rt;
      trap_valid = vecs[i].trap; trap_vector = vecs[i].tv; halt_req = vecs[i].halt;
      tick();
      check($sformatf("vec%0d_pc", i), fetch_pc, vecs[i].pc);
      check($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].h));
    end
    for (int i = 1; i <= 5; i++) begin
      idle(); redirect_valid = 1; redirect_target = 32'(i * 16);
      tick();
      idle(); call_push = 1;
      tick();
      check($sformatf("call%0d_pc", i), fetch_pc, 32'(i * 16 + 4));
    end
    idle(); redirect_valid = 1; redirect_target = 32'h1000;
    tick();
`ifdef RAS_EN
    exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
`else
    exp_ret = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};
`endif
    for (int i = 0; i < 5; i++) begin
      idle(); ret_pop = 1;
      tick();
      check($sformatf("ret%0d_pc", i), fetch_pc, exp_ret[i]);
    end
    for (int n = 0; n < 600; n++) begin
      idle();
      RST = ($urandom % 80) == 0;
      stall = ($urandom % 4) == 0;
      fetch_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_target = $urandom & 32'hFFFF_FFFC;
      trap_valid = ($urandom % 25) == 0;
      trap_vector = $urandom & 32'hFFFF_FFFC;
      halt_req = ($urandom % 20) == 0;
      call_push = ($urandom % 3) == 0;
      ret_pop = ($urandom % 3) == 0;
      tick();
      check("rand_pc", fetch_pc, m_pc);
      check("rand_valid", 32'(fetch_valid), 32'(m_valid));
      check("rand_halted", 32'(halted), 32'(m_halted));
      check("rand_plus", pc_plus_step, m_pc + 32'd4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch stage with an I-cache in front of memory. Holds the fetch PC and presents it to the I-cache with a valid/ready handshake. Selects the next PC from sequential, branch redirect and trap sources. Supports pipeline stall, halt, and an optional return-address stack. Sits between the hazard/branch logic in EX and the I-cache controller.

## Interface
Parameters:
- WIDTH, 32, PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2; used only with RAS_EN)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; blocks PC advance, keeps request presented
- fetch_ready  in  1  I-cache accepts fetch_pc this cycle (low on miss)
- redirect_valid  in  1  branch/jump taken, resolved in EX
- redirect_target  in  WIDTH  redirect destination
- trap_valid  in  1  exception/interrupt entry
- trap_vector  in  WIDTH  trap destination
- halt_req  in  1  stop fetching after current cycle
- call_push  in  1  accepted fetch is a call (RAS_EN only)
- ret_pop  in  1  accepted fetch is a return (RAS_EN only)
- fetch_valid  out  1  request valid to I-cache
- fetch_pc  out  WIDTH  current PC
- pc_plus_step  out  WIDTH  fetch_pc + STEP (combinational)
- halted  out  1  state is HALT

## Operation
- States: BOOT → RUN ↔ HALT. BOOT lasts exactly one cycle after RST deasserts and always goes to RUN.
- The request is accepted when fetch_valid & fetch_ready & !stall.
- Next-PC priority is RST > trap_valid > redirect_valid > accepted (sequential/RAS) > hold.
- trap_valid and redirect_valid act in RUN and HALT, and ignore stall and fetch_ready.
- An accepted request advances fetch_pc to pc_plus_step. Addition wraps modulo 2^WIDTH with no flag.
- halt_req in RUN enters HALT next cycle. PC holds, fetch_valid=0.
- Trap or redirect in HALT loads the new PC and returns to RUN. If halt_req and redirect arrive together, the redirect loads the PC and the state still enters HALT.
- While stalled or while fetch_ready=0, fetch_pc and fetch_valid stay stable. A redirect or trap may change fetch_pc while fetch_valid=1; the I-cache treats this as a new request.

## Timing
- Reset values: fetch_pc=RESET_VECTOR, fetch_valid=0, halted=0, state=BOOT, RAS empty.
- Cycle 0 after RST low is BOOT (fetch_valid=0). Cycle 1 is RUN (fetch_valid=1).
- One-cycle latency from an accepted request, redirect or trap to the new fetch_pc.
- RST asserted mid-miss or mid-stall: the next cycle holds reset values. No partial RAS update.

## Configuration
- RAS_EN defined: a RAS_DEPTH-entry circular stack is compiled in. Ports call_push and ret_pop are used.
  - Call: on accept, pc_plus_step is pushed.
  - Return: on accept with the RAS non-empty, the next PC is the top entry, which is popped.
  - Return on an empty RAS advances sequentially.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - call_push and ret_pop together replace the top entry with pc_plus_step, and the next PC is the old top.
  - trap or redirect takes priority, and the RAS is not updated that cycle.
- RAS_EN undefined: call_push and ret_pop stay as ports but are ignored. Only sequential, redirect and trap sources exist.

## Structure
- Shared package pc_gen_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the next-PC source select constants (SRC_HOLD, SRC_SEQ, SRC_RAS, SRC_REDIR, SRC_TRAP).
- One sub-module, pc_gen_ras, holds the stack storage, pointer and count. It is instantiated only under RAS_EN.

## Test plan
- Reset, then release with RESET_VECTOR=0x100 and fetch_ready=1 → BOOT cycle with fetch_valid=0, then fetch_pc sequence 0x100, 0x104, 0x108.
- fetch_ready=0 for 3 cycles at PC 0x200 with stall=0 → fetch_pc holds 0x200 with fetch_valid=1; 0x204 one cycle after ready rises.
- trap_valid (vector 0x80) and redirect_valid (target 0x400) in the same cycle, with stall=1 → next fetch_pc=0x80.
- halt_req at PC 0x300 → halted=1, fetch_valid=0, PC holds. Then redirect to 0x500 → RUN with fetch_pc=0x500.
- PC at 0xFFFF_FFFC accepted → wraps to 0x0000_0000.
- RAS_EN, depth 4: 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns → returns to 0x54, 0x44, 0x34, 0x24, then the 5th return is sequential (empty stack).
